// File: rtl/nibble_serial_adder16_pkg.sv
// nibble_serial_adder16_pkg: shared slice width, FSM state type and counter-width helper
// Contents: SLICE_W (nibble width), state_t {IDLE, RUN, DONE}, cnt_w(n) counter width with minimum 1.
package adder_pkg;
    localparam int SLICE_W = 4;
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
    function automatic int cnt_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction
endpackage

// File: rtl/nibble_serial_adder16_if.sv
// nibble_serial_adder16_if: operand/result handshake bus of the nibble-serial adder
// Signals: in_valid/in_ready + X, Y, Cin (operand side); out_valid/out_ready + Sum, Cout, Ovf (result side); busy.
// master drives operands and out_ready, slave is the adder.
interface nibble_serial_adder16_if #(parameter int WIDTH = 16);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] X;
    logic [WIDTH-1:0] Y;
    logic             Cin;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] Sum;
    logic             Cout;
    logic             Ovf;
    logic             busy;
    modport master (output in_valid, X, Y, Cin, out_ready,
                    input  in_ready, out_valid, Sum, Cout, Ovf, busy);
    modport slave  (input  in_valid, X, Y, Cin, out_ready,
                    output in_ready, out_valid, Sum, Cout, Ovf, busy);
endinterface

// File: rtl/nibble_serial_adder16_slice.sv
// fourbit_ripple: combinational 4-bit ripple-carry adder slice
// Ports: X, Y (4-bit addends), Cin (carry-in), Sum (4-bit sum), Cout (carry-out).
module fourbit_ripple
    import adder_pkg::*;
(
    input  logic [SLICE_W-1:0] X,
    input  logic [SLICE_W-1:0] Y,
    input  logic               Cin,
    output logic [SLICE_W-1:0] Sum,
    output logic               Cout
);
    logic [SLICE_W:0] w_c;
    assign w_c[0] = Cin;
    for (genvar i = 0; i < SLICE_W; i++) begin : g_fa
        assign Sum[i]     = X[i] ^ Y[i] ^ w_c[i];
        assign w_c[i + 1] = (X[i] & Y[i]) | (w_c[i] & (X[i] ^ Y[i]));
    end
    assign Cout = w_c[SLICE_W];
endmodule

// File: rtl/nibble_serial_adder16.sv
// nibble_serial_adder16: multi-cycle WIDTH-bit adder reusing one 4-bit ripple slice, LSB nibble first
// Ports: clk, rst_n (async active-low); bus (slave): in_valid/in_ready, X, Y, Cin,
//        out_valid/out_ready, Sum, Cout, Ovf (registered), busy (RUN or DONE).
module nibble_serial_adder16
    import adder_pkg::*;
#(
    parameter int WIDTH = 16
)(
    input logic clk,
    input logic rst_n,
    nibble_serial_adder16_if.slave bus
);
    localparam int NSLICE = WIDTH / SLICE_W;
    localparam int KW = cnt_w(NSLICE);
    localparam logic [KW-1:0] LAST = KW'(NSLICE - 1);

    if (WIDTH < SLICE_W || WIDTH % SLICE_W != 0) begin : g_bad_width
        $error("nibble_serial_adder16: WIDTH must be a multiple of 4 and at least 4");
    end

    state_t             r_state, w_next;
    logic [WIDTH-1:0]   r_x, r_y, r_sum;
    logic               r_carry, r_cout, r_ovf;
    logic [KW-1:0]      r_k;
    logic [WIDTH-1:0]   w_x_sh, w_y_sh;
    logic [SLICE_W-1:0] w_s;
    logic               w_co, w_accept, w_last;

    // Shifting the active nibble down to bit 0 keeps the slice wiring index-free.
    assign w_x_sh   = r_x >> {r_k, 2'b00};
    assign w_y_sh   = r_y >> {r_k, 2'b00};
    assign w_accept = (r_state == IDLE) && bus.in_valid;
    assign w_last   = (r_k == LAST);

    fourbit_ripple u_slice (
        .X    (w_x_sh[SLICE_W-1:0]),
        .Y    (w_y_sh[SLICE_W-1:0]),
        .Cin  (r_carry),
        .Sum  (w_s),
        .Cout (w_co)
    );

    always_comb begin
        w_next = r_state;
        if (w_accept)                                   w_next = RUN;
        else if (r_state == RUN && w_last)              w_next = DONE;
        else if (r_state == DONE && bus.out_ready)      w_next = IDLE;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= IDLE;
        else        r_state <= w_next;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_x     <= '0;
            r_y     <= '0;
            r_sum   <= '0;
            r_carry <= 1'b0;
            r_cout  <= 1'b0;
            r_ovf   <= 1'b0;
            r_k     <= '0;
        end else if (w_accept) begin
            r_x     <= bus.X;
            r_y     <= bus.Y;
            r_carry <= bus.Cin;
            r_k     <= '0;
        end else if (r_state == RUN) begin
            r_sum[{r_k, 2'b00} +: SLICE_W] <= w_s;
            r_carry <= w_co;
            if (w_last) begin
                r_cout <= w_co;
                // Overflow: like-signed operands whose result sign differs; w_s MSB is the final Sum MSB.
                r_ovf  <= (r_x[WIDTH-1] == r_y[WIDTH-1]) && (w_s[SLICE_W-1] != r_x[WIDTH-1]);
            end else begin
                r_k <= r_k + 1'b1;
            end
        end
    end

    assign bus.in_ready  = (r_state == IDLE);
    assign bus.out_valid = (r_state == DONE);
    assign bus.busy      = (r_state != IDLE);
    assign bus.Sum       = r_sum;
    assign bus.Cout      = r_cout;
    assign bus.Ovf       = r_ovf;
endmodule
